// File: rtl/sra_pkg.sv
// Shared definitions for the SRA datapath: default operand sizing used by the
// ALU stage and the shifter, plus the shifter control-state encoding.
package sra_pkg;

    localparam int SRA_WIDTH = 8;
    localparam int SRA_SHW   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sra_state_e;

endpackage

// File: rtl/sra_shift_unit.sv
// Multi-cycle signed arithmetic right shifter, one bit per clock, with sticky flag.
// Optional feature macro SRA_ROUND_EN: round half toward +infinity instead of floor.
module sra_shift_unit
    import sra_pkg::*;
#(
    parameter int WIDTH = SRA_WIDTH,
    parameter int SHW   = SRA_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    // Shifting more than WIDTH-1 places only replicates the sign, so the count saturates there.
    localparam logic [SHW-1:0] MAX_SHAMT = SHW'(WIDTH - 1);

    function automatic logic [SHW-1:0] clamp_shamt(input logic [SHW-1:0] shamt);
        if (shamt > MAX_SHAMT) begin
            return MAX_SHAMT;
        end else begin
            return shamt;
        end
    endfunction

    sra_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SRA_ROUND_EN
    logic             rbit_q, rbit_d;
`endif

    // Next-state logic for the control FSM, shift register, counter and sticky bit.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
`ifdef SRA_ROUND_EN
        rbit_d   = rbit_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d   = in_data;
                    cnt_d    = clamp_shamt(in_shamt);
                    sticky_d = 1'b0;
`ifdef SRA_ROUND_EN
                    rbit_d   = 1'b0;
`endif
                    if (in_shamt == {SHW{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                sticky_d = sticky_q | data_q[0];
`ifdef SRA_ROUND_EN
                rbit_d   = data_q[0];
`endif
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; a low rst_n discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= {WIDTH{1'b0}};
            cnt_q       <= {SHW{1'b0}};
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SRA_ROUND_EN
            rbit_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SRA_ROUND_EN
            rbit_q      <= rbit_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sticky = sticky_q;

    // For shamt >= 1 the top two bits of data_q match, so adding the round bit cannot overflow.
`ifdef SRA_ROUND_EN
    assign out_data = data_q + {{(WIDTH-1){1'b0}}, rbit_q};
`else
    assign out_data = data_q;
`endif

endmodule

// File: tb/tb_sra_shift_unit.sv
// Self-checking bench for sra_shift_unit: directed vectors, randomized operations
// against an arithmetic reference model, backpressure, throughput and mid-op reset.
module tb_sra_shift_unit;

`ifdef SRA_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sticky;

    int checks;
    int errors;

    sra_shift_unit #(.WIDTH(8), .SHW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(x / 2^s), or floor(x / 2^s + 1/2) when rounding is built in.
    function automatic logic [7:0] model_data(input logic [7:0] d, input int s);
        int x;
        int p;
        int q;
        x = int'($signed(d));
        p = 1 << s;
        if (ROUND && s > 0) x = x + p / 2;
        q = x / p;
        if ((x % p != 0) && (x < 0)) q = q - 1;
        return q[7:0];
    endfunction

    function automatic logic model_sticky(input logic [7:0] d, input int s);
        int mask;
        mask = (1 << s) - 1;
        return ((int'(d) & mask) != 0);
    endfunction

    task automatic do_op(input logic [7:0] d, input logic [2:0] s, input int hold,
                         output logic [7:0] od, output logic os, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        od = out_data;
        os = out_sticky;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 8'h00;
        in_shamt = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sticky !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h sticky=%b ready=%b, want 0 00 0 0",
                     out_valid, out_data, out_sticky, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] vd  [5] = '{8'hB4, 8'hF9, 8'h7F, 8'h80, 8'h5A};
        logic [2:0] vs  [5] = '{3'd2, 3'd1, 3'd7, 3'd7, 3'd0};
        logic [7:0] vtr [5] = '{8'hED, 8'hFC, 8'h00, 8'hFF, 8'h5A};
        logic [7:0] vrd [5] = '{8'hED, 8'hFD, 8'h01, 8'hFF, 8'h5A};
        logic       vst [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] od;
        logic [7:0] exp_d;
        logic       os;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            do_op(vd[i], vs[i], 0, od, os, lat);
            exp_d = ROUND ? vrd[i] : vtr[i];
            checks++;
            if (od !== exp_d) begin
                errors++;
                $display("FAIL directed_data[%0d]: got %h want %h", i, od, exp_d);
            end
            checks++;
            if (os !== vst[i]) begin
                errors++;
                $display("FAIL directed_sticky[%0d]: got %b want %b", i, os, vst[i]);
            end
            checks++;
            if (lat != int'(vs[i]) + 1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, int'(vs[i]) + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] od;
        logic [2:0] s;
        logic       os;
        int         lat;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            s = 3'($urandom_range(0, 7));
            do_op(d, s, int'($urandom_range(0, 3)), od, os, lat);
            checks++;
            if (od !== model_data(d, int'(s)) || os !== model_sticky(d, int'(s)) || lat != int'(s) + 1) begin
                errors++;
                $display("FAIL random[%0d] d=%h s=%0d: got data=%h sticky=%b lat=%0d want %h %b %0d",
                         i, d, s, od, os, lat, model_data(d, int'(s)), model_sticky(d, int'(s)), int'(s) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       exp_s;
        int         w;
        d = 8'($urandom);
        exp_d = model_data(d, 3);
        exp_s = model_sticky(d, 3);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 3'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_shamt = 3'd1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_sticky !== exp_s || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h sticky=%b ready=%b want 1 %h %b 0",
                         i, out_valid, out_data, out_sticky, in_ready, exp_d, exp_s);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got ready=%b want 0", in_ready);
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== model_data(8'h01, 1) || out_sticky !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got valid=%b data=%h sticky=%b want 1 %h 1",
                     out_valid, out_data, out_sticky, model_data(8'h01, 1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic       exps_q [$];
        logic [7:0] ed;
        logic       es;
        logic       acc;
        int         last_acc;
        int         last_s;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        in_shamt  = 3'($urandom_range(0, 7));
        last_acc  = -1;
        last_s    = 0;
        for (int c = 0; c < 140; c++) begin
            acc = in_valid && in_ready;
            checks++;
            if (acc && out_valid) begin
                errors++;
                $display("FAIL b2b_overlap[%0d]: input and output handshakes in one cycle", c);
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (c - last_acc != last_s + 2) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d want %0d", c - last_acc, last_s + 2);
                    end
                end
                last_acc = c;
                last_s   = int'(in_shamt);
                exp_q.push_back(model_data(in_data, int'(in_shamt)));
                exps_q.push_back(model_sticky(in_data, int'(in_shamt)));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got data=%h with nothing outstanding", out_data);
                end else begin
                    ed = exp_q.pop_front();
                    es = exps_q.pop_front();
                    if (out_data !== ed || out_sticky !== es) begin
                        errors++;
                        $display("FAIL b2b_result: got %h/%b want %h/%b", out_data, out_sticky, ed, es);
                    end
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                in_data  = 8'($urandom);
                in_shamt = 3'($urandom_range(0, 7));
            end
            if (c == 119) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || last_acc < 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d outstanding (last accept %0d) want 0", exp_q.size(), last_acc);
        end
    endtask

    task automatic test_reset_mid_op();
        int stale;
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(1, 255));
        in_shamt = 3'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sticky !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got valid=%b data=%h sticky=%b ready=%b want 0 00 0 0",
                     out_valid, out_data, out_sticky, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", in_ready);
        end
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d cycles with out_valid want 0", stale);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
